// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Key codes are {col_idx[1:0], row_idx[1:0]}.
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } frame_res_t;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  function automatic logic [2:0] low_count(input logic [3:0] low);
    return {2'b00, low[0]} + {2'b00, low[1]} + {2'b00, low[2]} + {2'b00, low[3]};
  endfunction

  // Only meaningful when exactly one bit is set.
  function automatic logic [1:0] row_index(input logic [3:0] low);
    if (low[0])      return 2'd0;
    else if (low[1]) return 2'd1;
    else if (low[2]) return 2'd2;
    else             return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad matrix pins plus the key event outputs seen by downstream logic.
// master = scanner side, slave = matrix / consumer side.
interface keypad_if;
  import keypad_pkg::*;

  logic [NUM_ROWS-1:0] key_row;
  logic [NUM_COLS-1:0] key_col;
  logic [3:0]          key_code;
  logic                key_valid;
  logic                key_held;

  modport master (
    input  key_row,
    output key_col, key_code, key_valid, key_held
  );

  modport slave (
    output key_row,
    input  key_col, key_code, key_valid, key_held
  );

endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchronizer, resets to all-ones (idle level of pulled-up rows).
// Latency 2 clk; no backpressure.
module keypad_sync
  import keypad_pkg::*;
#(
  parameter int WIDTH = NUM_ROWS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, whole-frame debounce, one-cycle key event.
// Define KEYPAD_REPEAT_EN to re-pulse key_valid every REPEAT_FRAMES frames while held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 50
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.master bus
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_FRAMES);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_FRAMES - 1);

  if (SCAN_DIV < 4) begin : g_bad_scan_div
    $error("keypad_scanner: SCAN_DIV must be >= 4");
  end
  if (DEBOUNCE_FRAMES < 2) begin : g_bad_debounce
    $error("keypad_scanner: DEBOUNCE_FRAMES must be >= 2");
  end
  if (REPEAT_FRAMES < 1) begin : g_bad_repeat
    $error("keypad_scanner: REPEAT_FRAMES must be >= 1");
  end

  logic          r_run;
  logic [SW-1:0] r_slot;
  logic [1:0]    r_col;
  logic          w_slot_end;
  logic          w_frame_end;

  assign w_slot_end  = r_run && (r_slot == SLOT_LAST);
  assign w_frame_end = w_slot_end && (r_col == 2'd3);

  // r_run holds the columns released for the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_run  <= 1'b0;
      r_slot <= '0;
      r_col  <= 2'd0;
    end else if (!r_run) begin
      r_run <= 1'b1;
    end else if (w_slot_end) begin
      r_slot <= '0;
      r_col  <= r_col + 2'd1;
    end else begin
      r_slot <= r_slot + SW'(1);
    end
  end

  assign bus.key_col = r_run ? ~(4'b0001 << r_col) : 4'b1111;

  logic [NUM_ROWS-1:0] w_row_sync;

  keypad_sync #(
    .WIDTH (NUM_ROWS)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.key_row),
    .o_q (w_row_sync)
  );

  logic [3:0] w_low;
  logic [2:0] w_low_cnt;
  logic       r_acc_any;
  logic       r_acc_multi;
  logic [3:0] r_acc_code;
  logic       w_any;
  logic       w_multi;
  logic [3:0] w_res_code;
  frame_res_t w_res;

  assign w_low     = ~w_row_sync;
  assign w_low_cnt = low_count(w_low);

  // Running frame result including the column being sampled this cycle.
  always_comb begin
    w_any      = r_acc_any || (w_low_cnt != 3'd0);
    w_multi    = r_acc_multi || (w_low_cnt > 3'd1) || (r_acc_any && (w_low_cnt != 3'd0));
    w_res_code = r_acc_any ? r_acc_code : {r_col, row_index(w_low)};
    if (w_multi)    w_res = MULTI;
    else if (w_any) w_res = SINGLE;
    else            w_res = NONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc_any   <= 1'b0;
      r_acc_multi <= 1'b0;
      r_acc_code  <= 4'h0;
    end else if (w_frame_end) begin
      r_acc_any   <= 1'b0;
      r_acc_multi <= 1'b0;
      r_acc_code  <= 4'h0;
    end else if (w_slot_end) begin
      r_acc_any   <= w_any;
      r_acc_multi <= w_multi;
      r_acc_code  <= w_res_code;
    end
  end

  state_t        r_state;
  logic [3:0]    r_cand;
  logic [DW-1:0] r_cnt;
  logic [DW-1:0] r_rcnt;
  logic [3:0]    r_code;
  logic          r_valid;
  logic          r_held;
  logic          w_match_cand;
  logic          w_match_code;

  assign w_match_cand = (w_res == SINGLE) && (w_res_code == r_cand);
  assign w_match_code = (w_res == SINGLE) && (w_res_code == r_code);

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_FRAMES - 1);
  logic [RW-1:0] r_rep;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cand  <= 4'h0;
      r_cnt   <= '0;
      r_rcnt  <= '0;
      r_code  <= 4'h0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep   <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      if (w_frame_end) begin
        unique case (r_state)
          IDLE: begin
            if (w_res == SINGLE) begin
              r_state <= DEBOUNCE;
              r_cand  <= w_res_code;
              r_cnt   <= DW'(1);
            end
          end
          DEBOUNCE: begin
            if (w_match_cand) begin
              if (r_cnt == DB_LAST) begin
                r_state <= PRESSED;
                r_code  <= r_cand;
                r_valid <= 1'b1;
                r_held  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                r_rep   <= '0;
`endif
              end else begin
                r_cnt <= r_cnt + DW'(1);
              end
            end else if (w_res == SINGLE) begin
              r_cand <= w_res_code;
              r_cnt  <= DW'(1);
            end else begin
              r_state <= IDLE;
            end
          end
          PRESSED: begin
            if (w_match_code) begin
`ifdef KEYPAD_REPEAT_EN
              if (r_rep == REP_LAST) begin
                r_valid <= 1'b1;
                r_rep   <= '0;
              end else begin
                r_rep <= r_rep + RW'(1);
              end
`endif
            end else begin
              r_state <= RELEASE;
              r_rcnt  <= (w_res == NONE) ? DW'(1) : '0;
            end
          end
          RELEASE: begin
            // A different key during release restarts the release count.
            if (w_res == NONE) begin
              if (r_rcnt == DB_LAST) begin
                r_state <= IDLE;
                r_held  <= 1'b0;
              end else begin
                r_rcnt <= r_rcnt + DW'(1);
              end
            end else if (w_match_code) begin
              r_state <= PRESSED;
            end else begin
              r_rcnt <= '0;
            end
          end
        endcase
      end
    end
  end

  assign bus.key_code  = r_code;
  assign bus.key_valid = r_valid;
  assign bus.key_held  = r_held;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 membrane keypad and is the input-side counterpart of the team's digit-scan display driver.
- Drives one active-low column at a time and samples active-low rows through a synchronizer.
- Debounces whole scan frames and emits a single-cycle key event plus a 4-bit key code.
- Downstream mode and selection logic consume key_code/key_valid in place of the hard-wired switch values.

Parameters:
SCAN_DIV, 1000, clocks each column is driven low per slot; legal range >= 4.
DEBOUNCE_FRAMES, 4, consecutive identical frames required for both press and release; legal range >= 2.
REPEAT_FRAMES, 50, frames between auto-repeat events; used only with KEYPAD_REPEAT_EN.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset
key_row  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk
key_col  output  4  keypad columns, active-low, one-hot-zero while scanning
key_code  output  4  code of last accepted key = {col_idx[1:0], row_idx[1:0]}
key_valid  output  1  one-cycle pulse when a key is accepted
key_held  output  1  high while the accepted key is considered pressed

Behaviour:
- Reset: synchronous, active-low. rst==0 forces the following on the next clk edge:
  - key_col=4'b1111, key_code=0, key_valid=0, key_held=0
  - state IDLE, slot counter 0, column index 0, synchronizer flops 4'b1111, all frame/debounce counters 0
- Reset mid-press: the press is discarded; no key_valid is produced for it.
- Column scan:
  - First cycle after reset release drives column 0 (key_col=4'b1110), followed by 1101, 1011, 0111, then wraps.
  - Each column stays low for exactly SCAN_DIV clocks. Frame = 4*SCAN_DIV clocks.
- Row synchronization and sampling:
  - key_row passes through a 2-flop synchronizer.
  - Rows are sampled on the last clock of each column slot. SCAN_DIV>=4 guarantees sync settling.
- Frame result, evaluated at the frame end (the column-3 sample):
  - NONE: zero low rows seen across the frame.
  - SINGLE(K): exactly one low bit seen across the frame; K={col_idx, row_idx}.
  - MULTI: two or more low bits seen across the frame.
- FSM, transitions only at frame end:
  - IDLE: SINGLE(K) -> DEBOUNCE with cand=K, cnt=1. NONE or MULTI -> stay in IDLE.
  - DEBOUNCE:
    - SINGLE(cand) -> cnt+1. When cnt reaches DEBOUNCE_FRAMES -> PRESSED; key_code<=cand; key_valid=1 for one clk; key_held<=1.
    - SINGLE(other) -> restart with cand=other, cnt=1.
    - NONE or MULTI -> IDLE.
  - PRESSED: SINGLE(key_code) -> stay. Anything else -> RELEASE with rcnt = 1 if NONE, else 0.
  - RELEASE:
    - NONE -> rcnt+1. When rcnt reaches DEBOUNCE_FRAMES -> IDLE; key_held<=0.
    - SINGLE(key_code) -> PRESSED with no new key_valid (bounce absorbed).
    - Other SINGLE or MULTI -> rcnt<=0 and stay in RELEASE; a second key is not accepted until all keys are released.
- Latency:
  - key_valid asserts on the clk after the frame end of the DEBOUNCE_FRAMES-th matching frame.
  - A clean press is accepted within (DEBOUNCE_FRAMES+1)*4*SCAN_DIV+2 clocks.
- Output holding:
  - key_code holds its value until the next accepted key.
  - key_valid never asserts in two consecutive cycles.

Optional Feature:
- Macro KEYPAD_REPEAT_EN defined:
  - In PRESSED, a frame counter increments each frame.
  - When the counter reaches REPEAT_FRAMES, key_valid pulses again with the same key_code and the counter clears.
  - The counter clears on entry to PRESSED and on reset. RELEASE->PRESSED bounces do not clear it.
- Macro undefined: exactly one key_valid per press, no repeat counter logic.

Decomposition:
- Package keypad_pkg:
  - NUM_COLS=4, NUM_ROWS=4
  - state encoding IDLE/DEBOUNCE/PRESSED/RELEASE
  - frame result encoding NONE/SINGLE/MULTI
  - named key code constants (KEY_0..KEY_F)
- Sub-module keypad_sync: parameterized-width 2-flop synchronizer with reset value all-ones.
- Column counter, frame accumulator and FSM stay in keypad_scanner.

Test Plan:
Bench setup: SCAN_DIV=4, DEBOUNCE_FRAMES=3, REPEAT_FRAMES=5; the matrix model pulls row r low only when col c is low and key (c,r) is pressed.
- Reset and scan: hold rst=0 for 3 clks, then release -> key_col=1111 during reset, then 1110 for 4 clks, 1101, 1011, 0111, 1110 repeating; all outputs 0.
- Clean press: press key (col 2,row 1) for 10 frames -> one key_valid pulse, key_code=4'h9, key_held=1. Release -> key_held=0 after 3 NONE frames.
- Bounce: press (1,3) for 1 frame, release for 1 frame, press for 5 frames -> exactly one key_valid, key_code=4'h7, no pulse before the 3rd consecutive matching frame.
- Multi-key: press (0,0) and (3,3) together for 10 frames -> no key_valid, state returns to IDLE, key_code unchanged.
- Reset mid-press: press (0,2), assert rst at frame 2 of debounce -> no key_valid; after release of rst, the same held key is accepted 3 frames later with key_code=4'h2.
- Repeat (KEYPAD_REPEAT_EN): hold (3,0) for 20 frames -> key_valid at acceptance, then every 5 frames, key_code=4'hC throughout; without the macro -> exactly one pulse.
